pipeline_hazard_controller: RTL and testbench

- Produces the control inputs consumed by the XM23 pipeline register bank: stall vector, register writeback port and PSW update mask/value.
- Tracks in-flight destination registers in a 3-stage scoreboard (execute, memory, writeback) and detects RAW and load-use hazards.
- Runs the data-memory request/acknowledge handshake with a timeout.
- Sits between decode, the ALU, data memory and the pipeline register bank.

---
 rtl/pipeline_hazard_controller.sv | 178 +++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// XM23 hazard/control unit: 3-entry scoreboard (EX/MEM/WB), RAW and load-use stalls, data-memory handshake with timeout.
// Build option: PIPE_FORWARD_EN adds fwd_sel_a/fwd_sel_b and restricts RAW stalls to load-use.

module pipeline_hazard_controller #(
  parameter  int NUM_REGS    = 8,
  parameter  int MEM_TIMEOUT = 15,
  parameter  int STALL_W     = 8,
  localparam int DW          = $clog2(NUM_REGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic [DW-1:0]      dec_src_a,
  input  logic               dec_src_a_used,
  input  logic [DW-1:0]      dec_src_b,
  input  logic               dec_src_b_used,
  input  logic [DW-1:0]      dec_dst,
  input  logic               dec_dst_wr,
  input  logic               dec_is_mem,
  input  logic               dec_is_load,
  input  logic [15:0]        ex_result,
  input  logic [15:0]        ex_psw,
  input  logic [15:0]        ex_psw_mask,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [15:0]        mem_rdata,
  output logic [STALL_W-1:0] stall_out,
  output logic               reg_write_enable,
  output logic [DW:0]        reg_write_select,
  output logic [15:0]        reg_write_value,
  output logic [15:0]        psw_mask_o,
  output logic [15:0]        psw_o,
`ifdef PIPE_FORWARD_EN
  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
`endif
  output logic               fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] dst;
    logic          dst_wr;
    logic          is_mem;
    logic          is_load;
  } tag_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} mem_st_t;

  tag_t [2:0]  sb;
  logic [15:0] data1, data2;  // entry0 has no data yet: the ALU is still producing it
  tag_t        dec_tag;
  mem_st_t     state_q, state_d, cur_st;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mem_op1, advance, load_done;
  logic        raw_hit, lu_hit, st_raw;
  logic        unused_tag;

  assign dec_tag = '{valid: 1'b1, dst: dec_dst, dst_wr: dec_dst_wr,
                     is_mem: dec_is_mem, is_load: dec_is_load};
  assign unused_tag = ^{sb[2].is_mem, sb[2].is_load};

  // REQ is never registered: an idle FSM with a mem op in entry1 is already requesting
  assign mem_op1   = sb[1].valid && sb[1].is_mem;
  assign cur_st    = (state_q == IDLE && mem_op1) ? REQ : state_q;
  assign mem_req   = (cur_st == REQ) || (cur_st == WAIT);
  assign advance   = !(mem_op1 && !mem_ack && state_q != ERR);
  assign load_done = mem_req && mem_ack && sb[1].is_load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (cur_st)
      IDLE: cnt_d = '0;
      REQ: begin
        cnt_d   = '0;
        state_d = mem_ack ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(MEM_TIMEOUT - 1)) state_d = ERR;
        end
      end
      ERR: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hazards only matter for an instruction actually waiting in decode
  always_comb begin
    raw_hit = 1'b0;
    lu_hit  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (dec_valid && sb[k].valid && sb[k].dst_wr &&
          ((dec_src_a_used && sb[k].dst == dec_src_a) ||
           (dec_src_b_used && sb[k].dst == dec_src_b))) begin
        raw_hit = 1'b1;
        if (k == 0 && sb[k].is_load) lu_hit = 1'b1;
      end
    end
  end

`ifdef PIPE_FORWARD_EN
  assign st_raw = lu_hit;
`else
  assign st_raw = raw_hit;
`endif

  assign stall_out = STALL_W'({state_q == ERR, !advance, lu_hit, st_raw});

  always_ff @(posedge clk) begin
    if (rst) begin
      sb      <= '0;
      data1   <= '0;
      data2   <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ERR) fault <= 1'b1;
      if (advance) begin
        sb[2] <= sb[1];
        data2 <= load_done ? mem_rdata : (state_q == ERR ? 16'h0000 : data1);
        sb[1] <= sb[0];
        data1 <= ex_result;
        sb[0] <= (dec_valid && !st_raw) ? dec_tag : '0;
      end
    end
  end

  assign reg_write_enable = advance && sb[2].valid && sb[2].dst_wr;
  assign reg_write_select = {1'b0, sb[2].dst};
  assign reg_write_value  = data2;
  assign psw_mask_o       = (advance && sb[0].valid) ? ex_psw_mask : 16'h0000;
  assign psw_o            = ex_psw;

`ifdef PIPE_FORWARD_EN
  // Operand sources of the EX-stage instruction, checked against the older entries
  logic [DW-1:0] e0_src_a, e0_src_b;
  logic          e0_a_used, e0_b_used;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_src_a  <= '0;
      e0_src_b  <= '0;
      e0_a_used <= 1'b0;
      e0_b_used <= 1'b0;
    end else if (advance) begin
      e0_src_a  <= dec_src_a;
      e0_src_b  <= dec_src_b;
      e0_a_used <= dec_valid && !st_raw && dec_src_a_used;
      e0_b_used <= dec_valid && !st_raw && dec_src_b_used;
    end
  end

  function automatic logic [1:0] fwd_pick(input logic used, input logic [DW-1:0] src,
                                          input tag_t t1, input tag_t t2);
    if (used && t1.valid && t1.dst_wr && t1.dst == src) return 2'd1;
    if (used && t2.valid && t2.dst_wr && t2.dst == src) return 2'd2;
    return 2'd0;
  endfunction

  assign fwd_sel_a = fwd_pick(e0_a_used, e0_src_a, sb[1], sb[2]);
  assign fwd_sel_b = fwd_pick(e0_b_used, e0_src_b, sb[1], sb[2]);
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed vector table, corner-case sequences, and random traffic vs an in-flight-list model.

module tb_pipeline_hazard_controller;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_src_a_used, dec_src_b_used, dec_dst_wr, dec_is_mem, dec_is_load;
  logic [2:0]  dec_src_a, dec_src_b, dec_dst;
  logic [15:0] ex_result, ex_psw, ex_psw_mask, mem_rdata;
  logic        mem_ack, mem_req, reg_write_enable, fault;
  logic [7:0]  stall_out;
  logic [3:0]  reg_write_select;
  logic [15:0] reg_write_value, psw_mask_o, psw_o;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.NUM_REGS(8), .MEM_TIMEOUT(MEM_TIMEOUT), .STALL_W(8)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
    .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used), .dec_dst(dec_dst),
    .dec_dst_wr(dec_dst_wr), .dec_is_mem(dec_is_mem), .dec_is_load(dec_is_load),
    .ex_result(ex_result), .ex_psw(ex_psw), .ex_psw_mask(ex_psw_mask),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_out(stall_out), .reg_write_enable(reg_write_enable),
    .reg_write_select(reg_write_select), .reg_write_value(reg_write_value),
    .psw_mask_o(psw_mask_o), .psw_o(psw_o), .fault(fault)
  );

  int unsigned n_cmp, n_bad;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_src_a = 0; dec_src_a_used = 0; dec_src_b = 0; dec_src_b_used = 0;
    dec_dst = 0; dec_dst_wr = 0; dec_is_mem = 0; dec_is_load = 0;
    ex_result = 0; ex_psw = 0; ex_psw_mask = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic issue(input logic [2:0] sa, input logic sau, input logic [2:0] sb, input logic sbu,
                       input logic [2:0] dst, input logic wr, input logic mem, input logic ld);
    dec_valid = 1; dec_src_a = sa; dec_src_a_used = sau; dec_src_b = sb; dec_src_b_used = sbu;
    dec_dst = dst; dec_dst_wr = wr; dec_is_mem = mem; dec_is_load = ld;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic dv; logic [2:0] sa; logic sau; logic [2:0] sb; logic sbu;
    logic [2:0] dst; logic dwr; logic mem; logic ld; logic ack;
    logic [15:0] rdata; logic [15:0] exr;
    logic [7:0] e_stall; logic e_req; logic e_we; logic [3:0] e_sel; logic [15:0] e_val;
  } vec_t;
  vec_t tv[14];

  // ---------------- reference model: list of in-flight instructions ----------------
  typedef struct { bit v; bit [2:0] dst; bit wr; bit mem; bit ld; bit [15:0] data; } inst_t;
  inst_t m[3];
  int    waited;   // cycles the mem op in the MEM slot has already been held
  bit    mfault;

  task automatic reset_model();
    for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0, 0, 0, 0};
    waited = 0;
    mfault = 0;
  endtask

  initial begin
    int  frz;
    bit  seen;
    int  ack_pct;
    bit  busy, tmo, frozen, raw, lu, hit;
    inst_t nd;

    n_cmp = 0; n_bad = 0;
    tv[0]  = '{1,0,0,0,0, 1,1,0,0, 0,16'h0000,16'h0000, 8'h00,0,0,4'd0,16'h0000};
    tv[1]  = '{1,1,1,0,0, 2,1,0,0, 0,16'h0000,16'h1234, 8'h01,0,0,4'd0,16'h0000};
    tv[2]  = '{1,1,1,0,0, 2,1,0,0, 0,16'h0000,16'h0000, 8'h01,0,0,4'd0,16'h0000};
    tv[3]  = '{1,1,1,0,0, 2,1,0,0, 0,16'h0000,16'h0000, 8'h01,0,1,4'd1,16'h1234};
    tv[4]  = '{1,1,1,0,0, 2,1,0,0, 0,16'h0000,16'h0000, 8'h00,0,0,4'd0,16'h0000};
    tv[5]  = '{1,0,0,0,0, 3,1,1,1, 0,16'h0000,16'h5555, 8'h00,0,0,4'd0,16'h0000};
    tv[6]  = '{0,0,0,0,0, 0,0,0,0, 0,16'h0000,16'h0000, 8'h00,0,0,4'd0,16'h0000};
    tv[7]  = '{0,0,0,0,0, 0,0,0,0, 0,16'h0000,16'h0000, 8'h04,1,0,4'd2,16'h5555};
    tv[8]  = '{0,0,0,0,0, 0,0,0,0, 0,16'h0000,16'h0000, 8'h04,1,0,4'd2,16'h5555};
    tv[9]  = '{0,0,0,0,0, 0,0,0,0, 1,16'hBEEF,16'h0000, 8'h00,1,1,4'd2,16'h5555};
    tv[10] = '{1,0,0,0,0, 5,0,0,0, 0,16'h0000,16'h0000, 8'h00,0,1,4'd3,16'hBEEF};
    tv[11] = '{1,3,1,5,1, 6,1,0,0, 0,16'h0000,16'h0000, 8'h00,0,0,4'd0,16'h0000};
    tv[12] = '{1,0,0,6,1, 7,1,0,0, 0,16'h0000,16'h0000, 8'h01,0,0,4'd0,16'h0000};
    tv[13] = '{0,0,0,0,0, 0,0,0,0, 0,16'h0000,16'h0000, 8'h00,0,0,4'd5,16'h0000};

    idle_inputs();
    rst = 1;
    do_reset();
    #1;
    chk("rst_stall", stall_out, 0);  chk("rst_req", mem_req, 0);
    chk("rst_we", reg_write_enable, 0); chk("rst_sel", reg_write_select, 0);
    chk("rst_val", reg_write_value, 0); chk("rst_pswm", psw_mask_o, 0);
    chk("rst_psw", psw_o, 0);        chk("rst_fault", fault, 0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      dec_valid = tv[i].dv; dec_src_a = tv[i].sa; dec_src_a_used = tv[i].sau;
      dec_src_b = tv[i].sb; dec_src_b_used = tv[i].sbu; dec_dst = tv[i].dst;
      dec_dst_wr = tv[i].dwr; dec_is_mem = tv[i].mem; dec_is_load = tv[i].ld;
      mem_ack = tv[i].ack; mem_rdata = tv[i].rdata; ex_result = tv[i].exr;
      #1;
      chk($sformatf("tv%0d_stall", i), stall_out, tv[i].e_stall);
      chk($sformatf("tv%0d_req", i), mem_req, tv[i].e_req);
      chk($sformatf("tv%0d_we", i), reg_write_enable, tv[i].e_we);
      chk($sformatf("tv%0d_sel", i), reg_write_select, tv[i].e_sel);
      chk($sformatf("tv%0d_val", i), reg_write_value, tv[i].e_val);
    end

    // store that never gets acked: REQ + 15 WAIT cycles frozen, then one ERR cycle
    do_reset();
    @(negedge clk); issue(0, 0, 0, 0, 4, 0, 1, 0);
    @(negedge clk); idle_inputs();
    frz = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (stall_out == 8'h04) frz++;
      else if (stall_out[3]) begin
        seen = 1;
        chk("to_stall", stall_out, 8'h08);
        chk("to_fault_during", fault, 0);
        chk("to_req_err", mem_req, 0);
      end
      @(negedge clk);
    end
    chk("to_seen", seen, 1);
    chk("to_freeze_cycles", 16'(frz), 16'(MEM_TIMEOUT + 1));
    #1;
    chk("to_fault_set", fault, 1);
    chk("to_resume_stall", stall_out, 0);
    repeat (5) @(negedge clk);
    #1 chk("to_fault_sticky", fault, 1);

    // reset while a load sits in WAIT (fault is still set from above)
    @(negedge clk); issue(0, 0, 0, 0, 2, 1, 1, 1);
    @(negedge clk); idle_inputs();
    @(negedge clk); #1 chk("rw_req_req", mem_req, 1);
    @(negedge clk); #1 chk("rw_req_wait", mem_req, 1); chk("rw_wait_stall", stall_out, 8'h04);
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    chk("rw_req", mem_req, 0);      chk("rw_stall", stall_out, 0);
    chk("rw_we", reg_write_enable, 0); chk("rw_sel", reg_write_select, 0);
    chk("rw_val", reg_write_value, 0); chk("rw_pswm", psw_mask_o, 0);
    chk("rw_psw", psw_o, 0);        chk("rw_fault", fault, 0);
    rst = 0;
    @(negedge clk); #1 chk("rw_discard", mem_req, 0);

    // PSW mask follows the EX entry and is suppressed while frozen
    do_reset();
    @(negedge clk); issue(0, 0, 0, 0, 3, 1, 1, 1); ex_psw_mask = 16'h000F; ex_psw = 16'h0005;
    #1 chk("psw_empty", psw_mask_o, 0);
    @(negedge clk); issue(0, 0, 0, 0, 4, 1, 0, 0);
    #1 chk("psw_ld_ex", psw_mask_o, 16'h000F);
    @(negedge clk); dec_valid = 0;
    #1 chk("psw_frozen", psw_mask_o, 0); chk("psw_frz_stall", stall_out, 8'h04);
    chk("psw_val", psw_o, 16'h0005);
    @(negedge clk); mem_ack = 1;
    #1 chk("psw_adv", psw_mask_o, 16'h000F);

    // random traffic against the model
    do_reset();
    reset_model();
    ack_pct = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      case ((cyc / 250) % 4)
        0: ack_pct = 60;
        1: ack_pct = 25;
        2: ack_pct = 0;
        default: ack_pct = 90;
      endcase
      rst = ($urandom_range(0, 399) == 0);
      dec_valid = ($urandom_range(0, 9) < 7);
      dec_src_a = 3'($urandom_range(0, 3)); dec_src_a_used = 1'($urandom);
      dec_src_b = 3'($urandom_range(0, 3)); dec_src_b_used = 1'($urandom);
      dec_dst = 3'($urandom_range(0, 3));   dec_dst_wr = ($urandom_range(0, 9) < 8);
      dec_is_mem = ($urandom_range(0, 3) == 0); dec_is_load = dec_is_mem && 1'($urandom);
      mem_ack = ($urandom_range(0, 99) < ack_pct);
      mem_rdata = 16'($urandom); ex_result = 16'($urandom);
      ex_psw = 16'($urandom); ex_psw_mask = 16'($urandom);

      busy   = m[1].v && m[1].mem;
      tmo    = busy && (waited == MEM_TIMEOUT + 1);
      frozen = busy && !tmo && !mem_ack;
      raw = 0; lu = 0;
      for (int k = 0; k < 3; k++) begin
        hit = dec_valid && m[k].v && m[k].wr &&
              ((dec_src_a_used && m[k].dst == dec_src_a) || (dec_src_b_used && m[k].dst == dec_src_b));
        if (hit) raw = 1;
        if (hit && k == 0 && m[0].ld) lu = 1;
      end
      #1;
      chk("r_stall", stall_out, {12'h000, tmo, frozen, lu, raw});
      chk("r_req", mem_req, busy && !tmo);
      chk("r_we", reg_write_enable, !frozen && m[2].v && m[2].wr);
      chk("r_sel", reg_write_select, {1'b0, m[2].dst});
      chk("r_val", reg_write_value, m[2].data);
      chk("r_pswm", psw_mask_o, (!frozen && m[0].v) ? ex_psw_mask : 16'h0000);
      chk("r_psw", psw_o, ex_psw);
      chk("r_fault", fault, mfault);

      if (rst) reset_model();
      else if (frozen) waited++;
      else begin
        m[2] = m[1];
        if (tmo) m[2].data = 16'h0000;
        else if (busy && m[1].ld) m[2].data = mem_rdata;
        m[1] = m[0];
        m[1].data = ex_result;
        if (dec_valid && !raw) begin
          nd = '{1, dec_dst, dec_dst_wr, dec_is_mem, dec_is_load, 16'h0000};
          m[0] = nd;
        end else m[0] = '{0, 0, 0, 0, 0, 0};
        if (tmo) mfault = 1;
        waited = 0;
      end
    end
    rst = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
